// File: rtl/paula_audio_mixer.sv
// Four-channel Paula volume mixer: one shared signed multiplier walks the
// channels and accumulates ch0+ch3 into left and ch1+ch2 into right.
module paula_audio_mixer #(
  parameter int OUT_W = 15
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clk7_en,
  input  logic                    mix_strb,
  input  logic [7:0]              sample0,
  input  logic [7:0]              sample1,
  input  logic [7:0]              sample2,
  input  logic [7:0]              sample3,
  input  logic [6:0]              volume0,
  input  logic [6:0]              volume1,
  input  logic [6:0]              volume2,
  input  logic [6:0]              volume3,
  output logic signed [OUT_W-1:0] left,
  output logic signed [OUT_W-1:0] right,
  output logic                    valid,
  output logic                    busy,
  output logic                    overrun
);

  typedef enum logic [2:0] {IDLE, CH0, CH1, CH2, CH3, DONE} state_t;

  state_t             state_q, state_d;
  logic        [7:0]  snap_s [4];
  logic        [6:0]  snap_v [4];
  logic signed [14:0] acc_l, acc_r;
  logic               capture;
  logic        [1:0]  ch;
  logic        [6:0]  eff_vol;
  logic signed [14:0] mul_a, mul_b, product;
  logic               to_left;

  assign busy = (state_q == CH0) || (state_q == CH1) ||
                (state_q == CH2) || (state_q == CH3);

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: if (mix_strb) begin
        capture = 1'b1;
        state_d = CH0;
      end
      CH0: state_d = CH1;
      CH1: state_d = CH2;
      CH2: state_d = CH3;
      CH3: state_d = DONE;
      DONE: begin
        if (mix_strb) begin
          capture = 1'b1;
          state_d = CH0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ch = 2'd0;
    case (state_q)
      CH1:     ch = 2'd1;
      CH2:     ch = 2'd2;
      CH3:     ch = 2'd3;
      default: ch = 2'd0;
    endcase
    to_left = (ch == 2'd0) || (ch == 2'd3);
    // Bit 6 of AUDxVOL forces full volume (64) regardless of the low bits.
    eff_vol = snap_v[ch][6] ? 7'd64 : {1'b0, snap_v[ch][5:0]};
    mul_a   = {{7{snap_s[ch][7]}}, snap_s[ch]};
    mul_b   = {8'b0, eff_vol};
    product = mul_a * mul_b;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      acc_l   <= '0;
      acc_r   <= '0;
      left    <= '0;
      right   <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        snap_s[i] <= '0;
        snap_v[i] <= '0;
      end
    end else if (clk7_en) begin
      state_q <= state_d;
      valid   <= (state_q == DONE);
      overrun <= busy && mix_strb;
      if (state_q == DONE) begin
        left  <= OUT_W'(acc_l);
        right <= OUT_W'(acc_r);
      end
      // A capture in DONE clears the accumulators in the same edge that
      // publishes them, which is what makes back-to-back passes work.
      if (capture) begin
        snap_s[0] <= sample0;
        snap_s[1] <= sample1;
        snap_s[2] <= sample2;
        snap_s[3] <= sample3;
        snap_v[0] <= volume0;
        snap_v[1] <= volume1;
        snap_v[2] <= volume2;
        snap_v[3] <= volume3;
        acc_l     <= '0;
        acc_r     <= '0;
      end else if (busy) begin
        if (to_left) acc_l <= acc_l + product;
        else         acc_r <= acc_r + product;
      end
    end
  end

endmodule
